// File: rtl/pc_gen_if.sv
// Fetch PC bus between pc_gen (master) and the fetch stage (slave).
// PC_MISALIGN_TRAP_EN adds the misalign_err signal.
interface pc_gen_if #(
    parameter int XLEN         = 32,
    parameter int FETCH_BYTES  = 4,
    parameter int NUM_REDIRECT = 2
);
    logic                         pc_ready;
    logic [NUM_REDIRECT-1:0]      redirect_valid;
    logic [NUM_REDIRECT*XLEN-1:0] redirect_pc;
    logic                         halt_req;
    logic [XLEN-1:0]              pc;
    logic                         pc_valid;
    logic [FETCH_BYTES/4-1:0]     slot_mask;
    logic [NUM_REDIRECT-1:0]      redirect_ack;
    logic                         halted;
`ifdef PC_MISALIGN_TRAP_EN
    logic                         misalign_err;

    modport master (
        input  pc_ready, redirect_valid, redirect_pc, halt_req,
        output pc, pc_valid, slot_mask, redirect_ack, halted, misalign_err
    );
    modport slave (
        output pc_ready, redirect_valid, redirect_pc, halt_req,
        input  pc, pc_valid, slot_mask, redirect_ack, halted, misalign_err
    );
`else
    modport master (
        input  pc_ready, redirect_valid, redirect_pc, halt_req,
        output pc, pc_valid, slot_mask, redirect_ack, halted
    );
    modport slave (
        output pc_ready, redirect_valid, redirect_pc, halt_req,
        input  pc, pc_valid, slot_mask, redirect_ack, halted
    );
`endif
endinterface

// File: rtl/pc_gen.sv
// Fetch-group PC generator: boot delay, prioritised redirects, halt/resume.
// Optional PC_MISALIGN_TRAP_EN: redirect targets with bit 1 set go to TRAP_ADDR.
`ifndef RESET_ADDR
`define RESET_ADDR 32'h8000_0000
`endif

module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_ADDR   = `RESET_ADDR,
    parameter int              FETCH_BYTES  = 4,
    parameter int              NUM_REDIRECT = 2,
    parameter int              BOOT_DELAY   = 4,
    parameter logic [XLEN-1:0] TRAP_ADDR    = 32'h0000_0100
) (
    input  logic     clk,
    input  logic     reset,
    pc_gen_if.master bus
);
    localparam int              SLOTS    = FETCH_BYTES / 4;
    localparam int              CNT_W    = $clog2(BOOT_DELAY + 1);
    localparam logic [XLEN-1:0] GRP_MASK = XLEN'(FETCH_BYTES - 1);

    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

    state_t                  state_p0, state_nxt;
    logic [CNT_W-1:0]        cnt_p0;
    logic [XLEN-1:0]         pc_p0, pc_nxt, tgt, off;
    logic [NUM_REDIRECT-1:0] grant;
    logic                    redir;
`ifdef PC_MISALIGN_TRAP_EN
    logic                    mis_nxt, mis_p0;
`endif

    function automatic logic [XLEN-1:0] next_group(input logic [XLEN-1:0] a);
        return (a & ~GRP_MASK) + XLEN'(FETCH_BYTES);
    endfunction

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

    // Lowest index wins: scan high to low so the last hit overrides.
    always_comb begin
        grant = '0;
        tgt   = '0;
        for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
            if (bus.redirect_valid[i]) begin
                grant = NUM_REDIRECT'(1) << i;
                tgt   = bus.redirect_pc[i*XLEN +: XLEN];
            end
        end
        if (state_p0 == BOOT) grant = '0;
    end

    assign redir = |grant;

    always_comb begin
        pc_nxt = pc_p0;
`ifdef PC_MISALIGN_TRAP_EN
        mis_nxt = 1'b0;
`endif
        if (redir) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (tgt[1]) begin
                pc_nxt  = TRAP_ADDR;
                mis_nxt = 1'b1;
            end else begin
                pc_nxt = word_align(tgt);
            end
`else
            pc_nxt = word_align(tgt);
`endif
        end else if (state_p0 == RUN && bus.pc_ready) begin
            pc_nxt = next_group(pc_p0);
        end
    end

    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            BOOT:    if (cnt_p0 == CNT_W'(BOOT_DELAY - 1)) state_nxt = RUN;
            RUN:     if (bus.halt_req) state_nxt = HALTED;
            HALTED:  if (!bus.halt_req) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    // Stage p0: architectural state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p0 <= BOOT;
            cnt_p0   <= '0;
            pc_p0    <= RESET_ADDR;
`ifdef PC_MISALIGN_TRAP_EN
            mis_p0   <= 1'b0;
`endif
        end else begin
            state_p0 <= state_nxt;
            pc_p0    <= pc_nxt;
            if (state_p0 == BOOT) cnt_p0 <= cnt_p0 + 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
            mis_p0   <= mis_nxt;
`endif
        end
    end

    always_comb begin
        bus.pc_valid  = (state_p0 == RUN);
        bus.halted    = (state_p0 == HALTED);
        off           = (pc_p0 & GRP_MASK) >> 2;
        bus.slot_mask = '0;
        for (int i = 0; i < SLOTS; i++)
            bus.slot_mask[i] = bus.pc_valid && (XLEN'(i) >= off);
    end

    assign bus.pc           = pc_p0;
    assign bus.redirect_ack = grant;
`ifdef PC_MISALIGN_TRAP_EN
    assign bus.misalign_err = mis_p0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: one 4-byte-group instance and one 16-byte-group instance.
module tb_pc_gen;
    localparam logic [31:0] RA   = 32'h8000_0000;
    localparam logic [31:0] TRAP = 32'h0000_0100;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(32), .FETCH_BYTES(4),  .NUM_REDIRECT(2)) a_if ();
    pc_gen_if #(.XLEN(32), .FETCH_BYTES(16), .NUM_REDIRECT(2)) b_if ();

    pc_gen #(.XLEN(32), .RESET_ADDR(RA), .FETCH_BYTES(4), .NUM_REDIRECT(2),
             .BOOT_DELAY(4), .TRAP_ADDR(TRAP))
        u_a (.clk(clk), .reset(reset), .bus(a_if.master));

    pc_gen #(.XLEN(32), .RESET_ADDR(RA), .FETCH_BYTES(16), .NUM_REDIRECT(2),
             .BOOT_DELAY(4), .TRAP_ADDR(TRAP))
        u_b (.clk(clk), .reset(reset), .bus(b_if.master));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_if.pc_ready = 1'b1; a_if.halt_req = 1'b0;
        a_if.redirect_valid = '0; a_if.redirect_pc = '0;
        b_if.pc_ready = 1'b1; b_if.halt_req = 1'b0;
        b_if.redirect_valid = '0; b_if.redirect_pc = '0;
        step(); step();

        chk("rst_pc",     a_if.pc, RA);
        chk("rst_valid",  a_if.pc_valid, 0);
        chk("rst_halted", a_if.halted, 0);
        chk("rst_mask",   a_if.slot_mask, 0);
        chk("rst_mask16", b_if.slot_mask, 0);
`ifdef PC_MISALIGN_TRAP_EN
        chk("rst_mis",    a_if.misalign_err, 0);
`endif

        // Boot: redirects are ignored
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a_if.redirect_valid = 2'b01;
            a_if.redirect_pc    = {32'h0, 32'h0000_0500};
            #1;
            chk("boot_valid", a_if.pc_valid, 0);
            chk("boot_ack",   a_if.redirect_ack, 0);
            chk("boot_pc",    a_if.pc, RA);
            step();
        end
        a_if.redirect_valid = '0;
        chk("run_valid", a_if.pc_valid, 1);
        chk("run_pc0",   a_if.pc, RA);
        chk("run_mask16", b_if.slot_mask, 4'b1111);
        step();
        chk("run_pc1", a_if.pc, RA + 32'd4);
        step();
        chk("run_pc2", a_if.pc, RA + 32'd8);

        // Two redirects with pc_ready: channel 0 wins
        a_if.redirect_valid = 2'b11;
        a_if.redirect_pc    = {32'h0000_0300, 32'h0000_0200};
        #1;
        chk("arb_ack", a_if.redirect_ack, 2'b01);
        step();
        chk("arb_pc", a_if.pc, 32'h200);

        // Channel 1 alone to 0x40, then stall
        a_if.redirect_valid = 2'b10;
        a_if.redirect_pc    = {32'h0000_0040, 32'h0000_0000};
        #1;
        chk("ch1_ack", a_if.redirect_ack, 2'b10);
        step();
        a_if.redirect_valid = '0;
        a_if.pc_ready = 1'b0;
        chk("ch1_pc", a_if.pc, 32'h40);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_pc",    a_if.pc, 32'h40);
            chk("stall_valid", a_if.pc_valid, 1);
        end

        // Halt, redirect while halted, resume
        a_if.halt_req = 1'b1;
        step();
        chk("halt_valid",  a_if.pc_valid, 0);
        chk("halt_halted", a_if.halted, 1);
        chk("halt_pc",     a_if.pc, 32'h40);
        a_if.pc_ready = 1'b1;
        step();
        chk("halt_hold_pc", a_if.pc, 32'h40);
        a_if.redirect_valid = 2'b01;
        a_if.redirect_pc    = {32'h0, 32'h0000_0080};
        #1;
        chk("halt_ack", a_if.redirect_ack, 2'b01);
        step();
        a_if.redirect_valid = '0;
        chk("halt_redir_pc",  a_if.pc, 32'h80);
        chk("halt_still",     a_if.halted, 1);
        a_if.halt_req = 1'b0;
        a_if.pc_ready = 1'b0;
        step();
        chk("resume_valid", a_if.pc_valid, 1);
        chk("resume_pc",    a_if.pc, 32'h80);
        chk("resume_halt",  a_if.halted, 0);

        // Wrap at top of address space
        a_if.pc_ready = 1'b1;
        a_if.redirect_valid = 2'b01;
        a_if.redirect_pc    = {32'h0, 32'hFFFF_FFFC};
        step();
        a_if.redirect_valid = '0;
        chk("wrap_pre", a_if.pc, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc", a_if.pc, 32'h0);

        // Misaligned redirect target
        a_if.redirect_valid = 2'b01;
        a_if.redirect_pc    = {32'h0, 32'h0000_1002};
        step();
        a_if.redirect_valid = '0;
`ifdef PC_MISALIGN_TRAP_EN
        chk("mis_pc",  a_if.pc, TRAP);
        chk("mis_err", a_if.misalign_err, 1);
        step();
        chk("mis_err_clr", a_if.misalign_err, 0);
        chk("mis_next_pc", a_if.pc, TRAP + 32'd4);
`else
        chk("mis_pc", a_if.pc, 32'h1000);
        step();
        chk("mis_next_pc", a_if.pc, 32'h1004);
`endif

        // 16-byte groups: partial then full slot mask
        b_if.redirect_valid = 2'b01;
        b_if.redirect_pc    = {32'h0, 32'h0000_1008};
        step();
        b_if.redirect_valid = '0;
        chk("g16_pc0",   b_if.pc, 32'h1008);
        chk("g16_mask0", b_if.slot_mask, 4'b1100);
        step();
        chk("g16_pc1",   b_if.pc, 32'h1010);
        chk("g16_mask1", b_if.slot_mask, 4'b1111);
        chk("a_mask",    a_if.slot_mask, 1'b1);

        // Reset mid-run beats a redirect in the same cycle
        reset = 1'b1;
        a_if.redirect_valid = 2'b01;
        a_if.redirect_pc    = {32'h0, 32'h0000_0700};
        step();
        chk("mid_rst_pc",    a_if.pc, RA);
        chk("mid_rst_valid", a_if.pc_valid, 0);
        chk("mid_rst_mask",  a_if.slot_mask, 0);
        chk("mid_rst_b_pc",  b_if.pc, RA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
